uart_xcvr: RTL and testbench
============================

# uart_xcvr

Parametrised full-duplex UART transceiver: one transmitter and one oversampling receiver sharing a clock, with configurable data width, stop bits, bit period and optional parity. Supersedes the fixed 8-bit TX/RX pair and adds a ready/valid handshake on the transmit side, start-bit glitch rejection and error reporting on the receive side. Sits between the system bus logic and the serial pins.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4..65535.
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when parity is compiled in.

- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_BITS  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter can accept a word.
- txd  out  1  serial output; idle high.
- baud_tick  out  1  one-cycle pulse in the first cycle of every TX bit period.
- rxd  in  1  serial input; asynchronous to clk.
- rx_data  out  DATA_BITS  last received word.
- rx_valid  out  1  one-cycle pulse when a frame completes.
- rx_frame_err  out  1  stop bit sampled low; valid with rx_valid.
- rx_parity_err  out  1  parity mismatch; valid with rx_valid.

## Operation
- Reset values: txd=1, tx_ready=1, baud_tick=0, rx_data=0, rx_valid=0, rx_frame_err=0, rx_parity_err=0. Both FSMs go to IDLE. Reset mid-frame aborts the frame; txd goes high asynchronously.
- Frame format: start bit (0), DATA_BITS payload bits LSB first, optional parity bit, STOP_BITS stop bits (1).
- TX FSM: IDLE -> START -> DATA -> PARITY (only when compiled in) -> STOP -> IDLE. Each bit lasts exactly CLKS_PER_BIT cycles. A bit counter counts DATA_BITS and STOP_BITS.
- TX handshake: a word is accepted on a rising edge where tx_valid && tx_ready. tx_data is captured into a shift register at that edge. tx_ready is high in IDLE and in the final cycle of the last stop bit. This allows back-to-back frames with no idle gap.
- RX path: rxd passes through a 2-flop synchronizer. In IDLE, a high-to-low transition of the synchronized signal starts a half-bit count. At the mid-point of the start bit, rxd is resampled. If it is high, the event is a false start and the FSM returns to IDLE with no output. Otherwise each subsequent bit is sampled once at its mid-point: START -> DATA -> PARITY (optional) -> STOP.
- RX completion: one cycle after the mid-stop-bit sample, rx_data is updated, rx_valid pulses for one cycle, and the error flags are set for that cycle. The word is delivered even when an error flag is set. With STOP_BITS=2, only the first stop bit is checked, and the RX FSM returns to IDLE after it.
- Idle-line break: rxd held low produces one frame with rx_frame_err=1. No further frame starts until rxd returns high.

## Timing
- TX latency: the start bit appears on txd in the cycle after acceptance.
- TX frame length: (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 when parity is compiled in, else 0.
- RX latency: rx_valid arrives 2 (synchronizer) + CLKS_PER_BIT/2 (floor) + (DATA_BITS + P + 1) * CLKS_PER_BIT + 1 cycles after the falling edge on rxd.

## Configuration
- UART_PARITY_EN defined: the PARITY state exists in both FSMs. The TX parity bit is the XOR of the payload, inverted when PARITY_ODD=1. RX compares the received parity bit against the same computation and reports the result on rx_parity_err.
- UART_PARITY_EN undefined: no parity bit in either direction, rx_parity_err is tied to 0, and PARITY_ODD is ignored.

## Structure
- Package uart_pkg holds the FSM state enum (IDLE, START, DATA, PARITY, STOP) and the frame-length helper function.
- Sub-module uart_baud_cnt: a reloadable down-counter with load and half-load inputs and a terminal pulse. It is instantiated once for TX and once for RX.

## Test plan
- Use CLKS_PER_BIT=4, parity off, loopback txd->rxd. Send 8'h93 -> txd carries 0,1,1,0,0,1,0,0,1,1, each bit held 4 cycles. The frame is 40 cycles. rx_data=8'h93 with a single rx_valid pulse and no errors.
- Hold tx_valid high with 8'h93 then 8'hF3 -> tx_ready pulses only in the last stop-bit cycle, the frames are contiguous with no gap, and RX delivers both words in order.
- Compile with UART_PARITY_EN and PARITY_ODD=0, send 8'hF3 -> parity bit 0. Flip the parity bit on the line -> rx_parity_err=1 together with rx_valid.
- Force the stop bit low -> rx_frame_err=1 and rx_valid=1. Then drive a 1-cycle low glitch on an idle rxd -> no rx_valid.
- Assert reset for 1 cycle during the DATA state of TX -> txd=1 and tx_ready=1 immediately, and the next accepted word transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared FSM state encoding and frame-length helper for the
//                uart_xcvr transceiver. UART_PARITY_EN adds one parity bit
//                to every frame.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Common state encoding for the TX and RX sequencers.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

`ifdef UART_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Clock cycles occupied by one complete frame on the line.
  function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                               input int unsigned data_bits,
                                               input int unsigned stop_bits);
    return (1 + data_bits + PARITY_BITS + stop_bits) * clks_per_bit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_cnt
//  Description : Reloadable bit-period down-counter. load_i reloads a full
//                bit period, half_load_i reloads half a period; tick_o is
//                high while the count sits at zero (last cycle of a period).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic half_load_i,
  output logic tick_o
);

  localparam int unsigned c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);

  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  // Reload has priority; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = c_full;
    end else if (half_load_i) begin
      cnt_d = c_half;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - c_cnt_w'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_xcvr.sv
`default_nettype none
// ============================================================================
//  Module      : uart_xcvr
//  Description : Full-duplex UART transceiver: ready/valid transmitter and a
//                mid-bit sampling receiver with false-start rejection and
//                frame/parity error reporting.
//                Optional feature macro: UART_PARITY_EN (adds parity bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_xcvr #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 txd_o,
  output logic                 baud_tick_o,
  input  logic                 rxd_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rx_frame_err_o,
  output logic                 rx_parity_err_o
);

  import uart_pkg::*;

  localparam logic [3:0] c_last_data = 4'(DATA_BITS - 1);
  localparam logic [3:0] c_last_stop = 4'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
  // Parity bit that accompanies a payload word.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction
`endif

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  uart_state_e          tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic                 txd_q, txd_d;
  logic                 baud_tick_q;
  logic                 w_tx_load, w_tx_tick, w_tx_last, w_tx_accept;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_baud (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (w_tx_load),
    .half_load_i (1'b0),
    .tick_o      (w_tx_tick)
  );

  // Ready in IDLE and in the final cycle of the last stop bit, so a waiting
  // word follows the previous frame with no idle gap.
  assign w_tx_last   = (tx_state_q == STOP) && w_tx_tick && (tx_bit_q == c_last_stop);
  assign tx_ready_o  = (tx_state_q == IDLE) || w_tx_last;
  assign w_tx_accept = tx_valid_i && tx_ready_o;

  // TX next-state, shift and line-level logic.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    w_tx_load  = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      IDLE: ;
      START: begin
        if (w_tx_tick) begin
          tx_state_d = DATA;
          tx_bit_d   = '0;
          w_tx_load  = 1'b1;
        end
      end
      DATA: begin
        if (w_tx_tick) begin
          tx_shift_d = tx_shift_q >> 1;
          w_tx_load  = 1'b1;
          if (tx_bit_q == c_last_data) begin
            tx_bit_d = '0;
`ifdef UART_PARITY_EN
            tx_state_d = PARITY;
`else
            tx_state_d = STOP;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (w_tx_tick) begin
          tx_state_d = STOP;
          tx_bit_d   = '0;
          w_tx_load  = 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_tx_tick) begin
          if (tx_bit_q == c_last_stop) begin
            tx_state_d = IDLE;
          end else begin
            tx_bit_d  = tx_bit_q + 4'd1;
            w_tx_load = 1'b1;
          end
        end
      end
      default: tx_state_d = IDLE;
    endcase

    // An accepted word overrides the return to IDLE.
    if (w_tx_accept) begin
      tx_state_d = START;
      tx_shift_d = tx_data_i;
      w_tx_load  = 1'b1;
`ifdef UART_PARITY_EN
      tx_par_d   = parity_of(tx_data_i);
`endif
    end

    // Line level is derived from the upcoming state so txd is registered.
    case (tx_state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
      PARITY:  txd_d = tx_par_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  // TX state register; reset forces the line idle immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q  <= IDLE;
      tx_shift_q  <= '0;
      tx_bit_q    <= '0;
      txd_q       <= 1'b1;
      baud_tick_q <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q    <= 1'b0;
`endif
    end else begin
      tx_state_q  <= tx_state_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      txd_q       <= txd_d;
      baud_tick_q <= w_tx_load;
`ifdef UART_PARITY_EN
      tx_par_q    <= tx_par_d;
`endif
    end
  end

  assign txd_o       = txd_q;
  assign baud_tick_o = baud_tick_q;

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  logic                 rx_s1_q, rx_s2_q, rx_s3_q;
  uart_state_e          rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 w_rx_load, w_rx_half, w_rx_tick, w_rx_fall;
`ifdef UART_PARITY_EN
  logic                 rx_par_q, rx_par_d;
  logic                 rx_perr_q, rx_perr_d;
`endif

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_baud (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (w_rx_load),
    .half_load_i (w_rx_half),
    .tick_o      (w_rx_tick)
  );

  // Falling edge on the synchronized line; a line held low never re-arms.
  assign w_rx_fall = rx_s3_q && !rx_s2_q;

  // RX next-state, sampling and completion logic.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    w_rx_load  = 1'b0;
    w_rx_half  = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_d   = rx_par_q;
    rx_perr_d  = 1'b0;
`endif
    case (rx_state_q)
      IDLE: begin
        if (w_rx_fall) begin
          rx_state_d = START;
          w_rx_half  = 1'b1;
        end
      end
      START: begin
        if (w_rx_tick) begin
          if (rx_s2_q) begin
            rx_state_d = IDLE;          // glitch: line high again mid-start
          end else begin
            rx_state_d = DATA;
            rx_bit_d   = '0;
            w_rx_load  = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_rx_tick) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          w_rx_load  = 1'b1;
          if (rx_bit_q == c_last_data) begin
            rx_bit_d = '0;
`ifdef UART_PARITY_EN
            rx_state_d = PARITY;
`else
            rx_state_d = STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (w_rx_tick) begin
          rx_par_d   = rx_s2_q;
          rx_state_d = STOP;
          w_rx_load  = 1'b1;
        end
      end
`endif
      STOP: begin
        // Only the first stop bit is checked; extra stop bits look idle.
        if (w_rx_tick) begin
          rx_state_d = IDLE;
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          rx_ferr_d  = !rx_s2_q;
`ifdef UART_PARITY_EN
          rx_perr_d  = (rx_par_q != parity_of(rx_shift_q));
`endif
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // RX synchronizer, state and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= IDLE;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_s1_q    <= rxd_i;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
      rx_par_q   <= rx_par_d;
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_frame_err_o = rx_ferr_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err_o = rx_perr_q;
`else
  assign rx_parity_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_xcvr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_xcvr
//  Description : Directed self-checking bench for uart_xcvr (4 clocks/bit,
//                8 data bits, 1 stop bit, even parity when UART_PARITY_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_xcvr;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
  localparam logic [15:0] WAVE_93 = 16'b10100100110;
  localparam logic [15:0] WAVE_F3 = 16'b10111100110;
  localparam logic [15:0] WAVE_A5 = 16'b10101001010;
`else
  localparam int PAR = 0;
  localparam logic [15:0] WAVE_93 = 16'b1100100110;
  localparam logic [15:0] WAVE_F3 = 16'b1111100110;
  localparam logic [15:0] WAVE_A5 = 16'b1101001010;
`endif
  localparam int NB     = 10 + PAR;
  localparam int FC     = NB * CPB;
  localparam int RX_LAT = 2 + CPB / 2 + (8 + PAR + 1) * CPB + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, txd, baud_tick;
  logic       rxd, use_loop, rx_drv;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr, rx_perr;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [9:0] rxq[$];
  int         rxt[$];

  assign rxd = use_loop ? txd : rx_drv;

  uart_xcvr #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .txd_o(txd), .baud_tick_o(baud_tick), .rxd_i(rxd),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .rx_frame_err_o(rx_ferr), .rx_parity_err_o(rx_perr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Received-word log: {parity_err, frame_err, data} and arrival cycle.
  always @(negedge clk) begin
    if (rx_valid) begin
      rxq.push_back({rx_perr, rx_ferr, rx_data});
      rxt.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stretch a per-bit pattern to one sample per clock.
  function automatic logic [127:0] expand(input logic [15:0] p);
    logic [127:0] r = '0;
    for (int j = 0; j < NB; j++)
      for (int k = 0; k < CPB; k++) r[j*CPB+k] = p[j];
    return r;
  endfunction

  function automatic logic [127:0] tick_pattern(input int n);
    logic [127:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = (i % CPB == 0);
    return r;
  endfunction

  // Offer d0 (and d1 back-to-back when frames==2), capture line activity.
  task automatic send(input logic [7:0] d0, input logic [7:0] d1, input int frames,
                      output logic [127:0] w, output logic [127:0] tk,
                      output logic [127:0] rd, output int t0);
    w = '0; tk = '0; rd = '0; t0 = 0;
    @(negedge clk);
    tx_data  = d0;
    tx_valid = 1'b1;
    for (int i = 0; i < frames * FC; i++) begin
      @(negedge clk);
      w[i] = txd; tk[i] = baud_tick; rd[i] = tx_ready;
      if (i == 0) begin
        t0 = cyc;
        tx_data = d1;
        if (frames == 1) tx_valid = 1'b0;
      end
      if (i == FC) tx_valid = 1'b0;
    end
  endtask

  task automatic wait_rx(input int n);
    for (int k = 0; k < 200 && rxq.size() < n; k++) @(negedge clk);
  endtask

  task automatic pop_rx(output logic [9:0] e, output int t);
    if (rxq.size() == 0) begin
      e = 10'h3ff; t = -1;
    end else begin
      e = rxq.pop_front(); t = rxt.pop_front();
    end
  endtask

  // Drive a hand-built frame (bit 0 first) directly onto rxd.
  task automatic drive_frame(input logic [15:0] bits);
    use_loop = 1'b0;
    for (int j = 0; j < NB; j++) begin
      rx_drv = bits[j];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w, tk, rd;
    logic [9:0]   e;
    int           t0, t1;

    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; use_loop = 1'b1; rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_baud_tick", baud_tick, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_ferr", rx_ferr, 1'b0);
    check("rst_rx_perr", rx_perr, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame in loopback.
    rxq.delete(); rxt.delete();
    send(8'h93, 8'h00, 1, w, tk, rd, t0);
    check("tx93_wave", w, expand(WAVE_93));
    check("tx93_tick", tk, tick_pattern(FC));
    check("tx93_ready", rd, 128'(1) << (FC - 1));
    wait_rx(1);
    repeat (5) @(negedge clk);
    check("rx93_count", rxq.size(), 1);
    pop_rx(e, t1);
    check("rx93_word", e, {2'b00, 8'h93});
    check("rx93_latency", t1 - t0, RX_LAT);

    // Back-to-back frames with tx_valid held.
    repeat (4) @(negedge clk);
    rxq.delete(); rxt.delete();
    send(8'h93, 8'hF3, 2, w, tk, rd, t0);
    check("b2b_wave", w, expand(WAVE_93) | (expand(WAVE_F3) << FC));
    check("b2b_tick", tk, tick_pattern(2 * FC));
    check("b2b_ready", rd, (128'(1) << (FC - 1)) | (128'(1) << (2 * FC - 1)));
    wait_rx(2);
    repeat (5) @(negedge clk);
    check("b2b_count", rxq.size(), 2);
    pop_rx(e, t1);
    check("b2b_word0", e, {2'b00, 8'h93});
    pop_rx(e, t1);
    check("b2b_word1", e, {2'b00, 8'hF3});

`ifdef UART_PARITY_EN
    // Parity bit flipped on the line (even parity of F3 is 0).
    repeat (4) @(negedge clk);
    rxq.delete(); rxt.delete();
    drive_frame({5'b0, 1'b1, 1'b1, 8'hF3, 1'b0});
    wait_rx(1);
    check("perr_count", rxq.size(), 1);
    pop_rx(e, t1);
    check("perr_word", e, {2'b10, 8'hF3});
`endif

    // Stop bit forced low.
    repeat (4) @(negedge clk);
    rxq.delete(); rxt.delete();
`ifdef UART_PARITY_EN
    drive_frame({5'b0, 1'b0, 1'b0, 8'h5A, 1'b0});
`else
    drive_frame({6'b0, 1'b0, 8'h5A, 1'b0});
`endif
    wait_rx(1);
    repeat (5) @(negedge clk);
    check("ferr_count", rxq.size(), 1);
    pop_rx(e, t1);
    check("ferr_word", e, {2'b01, 8'h5A});

    // Reset during TX data bit 2 (a 0 bit of 8'h93).
    use_loop = 1'b1;
    repeat (4) @(negedge clk);
    rxq.delete(); rxt.delete();
    tx_data = 8'h93; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (13) @(negedge clk);
    check("prerst_txd", txd, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_txd", txd, 1'b1);
    check("midrst_tx_ready", tx_ready, 1'b1);
    check("midrst_rx_data", rx_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'hA5, 8'h00, 1, w, tk, rd, t0);
    check("postrst_wave", w, expand(WAVE_A5));
    wait_rx(1);
    repeat (5) @(negedge clk);
    check("postrst_count", rxq.size(), 1);
    pop_rx(e, t1);
    check("postrst_word", e, {2'b00, 8'hA5});

    // One-cycle low glitch on an idle line.
    use_loop = 1'b0;
    rxq.delete(); rxt.delete();
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_count", rxq.size(), 0);

    // Line break: exactly one errored all-zero frame.
    rx_drv = 1'b0;
    repeat (150) @(negedge clk);
    check("break_count", rxq.size(), 1);
    pop_rx(e, t1);
    check("break_word", e, {2'b01, 8'h00});
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    check("break_release_count", rxq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
